// File: rtl/rtlinf_act_unloader.sv
// Read-back master for the RTLinf activation memories: for each selected memory it
// assigns the local port, reads an address window, streams the words out, then unassigns.
module rtlinf_act_unloader #(
    parameter int GROUP_SIZE           = 4,
    parameter int DATA_WIDTH           = 8,
    parameter int NUM_KERNELS          = 8,
    parameter int LOG_NUM_KERNELS      = 3,
    parameter int NUM_ACT_MEMORIES     = 8,
    parameter int LOG_NUM_ACT_MEMORIES = 3,
    parameter int LOG_MAX_ADDRESS      = 12,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [NUM_ACT_MEMORIES-1:0]          i_mem_mask,
    input  logic [LOG_MAX_ADDRESS-1:0]           i_base_addr,
    input  logic [LOG_MAX_ADDRESS:0]             i_num_words,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_protocol_err,
    output logic                                 o_cmd_act_assign,
    output logic                                 o_cmd_act_unassign,
    output logic [LOG_NUM_KERNELS:0]             o_cmd_act_read_port,
    output logic [LOG_NUM_KERNELS:0]             o_cmd_act_write_port,
    output logic [LOG_NUM_ACT_MEMORIES-1:0]      o_cmd_act_memory,
    output logic                                 o_act_read,
    output logic [LOG_MAX_ADDRESS-1:0]           o_act_read_addr,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]     i_act_read_data,
    input  logic                                 i_act_read_valid,
    output logic                                 o_out_valid,
    input  logic                                 i_out_ready,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0]     o_out_data,
    output logic [LOG_NUM_ACT_MEMORIES-1:0]      o_out_mem,
    output logic [LOG_MAX_ADDRESS-1:0]           o_out_addr,
    output logic                                 o_out_last
);

    localparam int WORD_W = GROUP_SIZE * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ASSIGN, S_READ, S_DRAIN, S_UNASSIGN, S_FLUSH, S_DONE
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0]               data;
        logic [LOG_NUM_ACT_MEMORIES-1:0] mem;
        logic [LOG_MAX_ADDRESS-1:0]      addr;
        logic                            last;
    } entry_t;

    state_t                          r_state, w_next_state;
    logic [NUM_ACT_MEMORIES-1:0]     r_mask;
    logic [LOG_MAX_ADDRESS-1:0]      r_base;
    logic [LOG_MAX_ADDRESS:0]        r_num;
    logic [LOG_NUM_ACT_MEMORIES-1:0] r_mem;
    logic [LOG_MAX_ADDRESS:0]        r_issue_cnt;
    logic [LOG_MAX_ADDRESS:0]        r_resp_cnt;
    logic [CNT_W-1:0]                r_outstanding;
    logic [CNT_W-1:0]                r_count;
    logic [PTR_W-1:0]                r_wr_ptr;
    logic [PTR_W-1:0]                r_rd_ptr;
    logic                            r_protocol_err;
    entry_t                          r_fifo [FIFO_DEPTH];

    logic [LOG_NUM_ACT_MEMORIES-1:0] w_scan_mem;
    logic [NUM_ACT_MEMORIES-1:0]     w_cur_onehot;
    logic                            w_final_mem;
    logic                            w_act_read;
    logic                            w_issue_last;
    logic                            w_resp_accept;
    logic                            w_pop;
    entry_t                          w_push_entry;
    entry_t                          w_head;

    // Lowest set bit of the remaining mask picks the next memory.
    always_comb begin
        w_scan_mem = '0;
        for (int i = NUM_ACT_MEMORIES - 1; i >= 0; i--) begin
            if (r_mask[i]) w_scan_mem = LOG_NUM_ACT_MEMORIES'(i);
        end
    end

    assign w_cur_onehot  = NUM_ACT_MEMORIES'(1) << r_mem;
    assign w_final_mem   = (r_mask & ~w_cur_onehot) == '0;
    assign w_issue_last  = r_issue_cnt == r_num - (LOG_MAX_ADDRESS+1)'(1);
    assign w_resp_accept = i_act_read_valid && (r_outstanding != '0);
    assign w_pop         = o_out_valid && i_out_ready;
    // Slots count both in-flight reads and buffered words, so the FIFO can never overflow.
    assign w_act_read    = (r_state == S_READ) && (r_issue_cnt != r_num) &&
                           ((CNT_W+1)'(r_outstanding) + (CNT_W+1)'(r_count) < (CNT_W+1)'(FIFO_DEPTH));

    assign w_push_entry.data = i_act_read_data;
    assign w_push_entry.mem  = r_mem;
    assign w_push_entry.addr = r_base + r_resp_cnt[LOG_MAX_ADDRESS-1:0];
    assign w_push_entry.last = w_final_mem && (r_resp_cnt == r_num - (LOG_MAX_ADDRESS+1)'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every combinational block assigns its outputs a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next_state = S_SCAN;
            S_SCAN:     w_next_state = (r_mask == '0 || r_num == '0) ? S_FLUSH : S_ASSIGN;
            S_ASSIGN:   w_next_state = S_READ;
            S_READ:     if (w_act_read && w_issue_last) w_next_state = S_DRAIN;
            S_DRAIN:    if (r_outstanding == '0) w_next_state = S_UNASSIGN;
            S_UNASSIGN: w_next_state = S_SCAN;
            S_FLUSH:    if (r_count == '0) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy             = r_state != S_IDLE;
        o_done             = r_state == S_DONE;
        o_cmd_act_assign   = r_state == S_ASSIGN;
        o_cmd_act_unassign = r_state == S_UNASSIGN;
        o_act_read         = w_act_read;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask         <= '0;
            r_base         <= '0;
            r_num          <= '0;
            r_mem          <= '0;
            r_issue_cnt    <= '0;
            r_resp_cnt     <= '0;
            r_outstanding  <= '0;
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_mask <= i_mem_mask;
                r_base <= i_base_addr;
                r_num  <= i_num_words;
            end
            if (r_state == S_SCAN) begin
                r_mem       <= w_scan_mem;
                r_issue_cnt <= '0;
                r_resp_cnt  <= '0;
            end
            if (w_act_read)    r_issue_cnt <= r_issue_cnt + (LOG_MAX_ADDRESS+1)'(1);
            if (w_resp_accept) r_resp_cnt  <= r_resp_cnt + (LOG_MAX_ADDRESS+1)'(1);
            if (r_state == S_UNASSIGN) r_mask <= r_mask & ~w_cur_onehot;
            r_outstanding <= r_outstanding + CNT_W'(w_act_read) - CNT_W'(w_resp_accept);
            r_count       <= r_count + CNT_W'(w_resp_accept) - CNT_W'(w_pop);
            if (w_resp_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)         r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (i_act_read_valid && r_outstanding == '0) r_protocol_err <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by r_count and the head is gated by out_valid.
    always_ff @(posedge i_clk) begin
        if (w_resp_accept) r_fifo[r_wr_ptr] <= w_push_entry;
    end

    assign w_head               = r_fifo[r_rd_ptr];
    assign o_out_valid          = r_count != '0;
    assign o_out_data           = o_out_valid ? w_head.data : '0;
    assign o_out_mem            = o_out_valid ? w_head.mem  : '0;
    assign o_out_addr           = o_out_valid ? w_head.addr : '0;
    assign o_out_last           = o_out_valid && w_head.last;
    assign o_protocol_err       = r_protocol_err;
    assign o_cmd_act_memory     = r_mem;
    assign o_cmd_act_read_port  = (LOG_NUM_KERNELS+1)'(NUM_KERNELS);
    assign o_cmd_act_write_port = (LOG_NUM_KERNELS+1)'(NUM_KERNELS);
    assign o_act_read_addr      = r_base + r_issue_cnt[LOG_MAX_ADDRESS-1:0];

endmodule

// File: doc/rtlinf_act_unloader.md
# rtlinf_act_unloader

Hardware read-back master for the RTLinf activation memories. It drives the command and read ports that a host would otherwise toggle by hand:
- assigns each selected memory to the local external port (index NUM_KERNELS);
- reads a contiguous address window from that memory;
- streams the words out on a valid/ready interface tagged with memory index and address;
- unassigns the memory.

It sits between RTLinf and the host/DMA side and is the read-side counterpart to the bench/host write sequence.

## Interface
- GROUP_SIZE, 4, activations per word
- DATA_WIDTH, 8, bits per activation
- NUM_KERNELS, 8, kernel count; local port index = NUM_KERNELS
- LOG_NUM_KERNELS, 3, log2(NUM_KERNELS)
- NUM_ACT_MEMORIES, 8, activation memories
- LOG_NUM_ACT_MEMORIES, 3, log2(NUM_ACT_MEMORIES)
- LOG_MAX_ADDRESS, 12, address width
- FIFO_DEPTH, 4, output buffer entries; must exceed RTLinf read latency (power of 2, ≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch; sampled only in IDLE
- mem_mask  in  NUM_ACT_MEMORIES  memories to read, bit i = memory i
- base_addr  in  LOG_MAX_ADDRESS  first address
- num_words  in  LOG_MAX_ADDRESS+1  words per memory, 0..2^LOG_MAX_ADDRESS
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- protocol_err  out  1  sticky; act_read_valid with nothing outstanding
- cmd_act_assign / cmd_act_unassign  out  1  command pulses
- cmd_act_read_port, cmd_act_write_port  out  LOG_NUM_KERNELS+1  constant NUM_KERNELS
- cmd_act_memory  out  LOG_NUM_ACT_MEMORIES  target memory
- act_read  out  1  read request
- act_read_addr  out  LOG_MAX_ADDRESS  read address
- act_read_data  in  GROUP_SIZE*DATA_WIDTH  read data
- act_read_valid  in  1  read data valid, in request order
- out_valid / out_ready  out / in  1  stream handshake
- out_data  out  GROUP_SIZE*DATA_WIDTH  word
- out_mem  out  LOG_NUM_ACT_MEMORIES  source memory
- out_addr  out  LOG_MAX_ADDRESS  source address
- out_last  out  1  last word of the whole operation

## Operation
- start in IDLE latches mem_mask, base_addr and num_words. Inputs are ignored while busy.
- FSM states:
  - IDLE
  - SCAN: pick the lowest set bit of the remaining mask. If none, or num_words=0, go to FLUSH. Otherwise go to ASSIGN.
  - ASSIGN: 1 cycle, cmd_act_assign=1, cmd_act_memory=m.
  - READ: issue reads until num_words have been issued.
  - DRAIN: wait until outstanding=0.
  - UNASSIGN: 1 cycle, cmd_act_unassign=1. Clear bit m, go to SCAN.
  - FLUSH: wait until the FIFO is empty.
  - DONE: 1 cycle, done=1, then IDLE.
- Read issue rule: act_read=1 when in READ, reads remain, and outstanding + fifo_count < FIFO_DEPTH.
  - A FIFO pop in the same cycle frees its slot only in the next cycle.
- Issue address = (base_addr + i) mod 2^LOG_MAX_ADDRESS, so reads wrap at the top of the address space.
- Each act_read_valid pushes one FIFO entry: {data, m, response address, last}.
  - last = final word of the final selected memory.
  - Response address comes from a separate counter that resets per memory.
- act_read_valid with outstanding=0 is dropped and sets protocol_err (cleared only by rst).
- The FIFO is first-word-fall-through: out_valid = not empty; pop on out_valid && out_ready.
- busy=1 in every state except IDLE.
- Reset (any time, including mid-operation):
  - FSM to IDLE, FIFO emptied, counters cleared.
  - All outputs 0 except cmd_act_read_port/cmd_act_write_port, which stay NUM_KERNELS.
  - No unassign is issued on reset; RTLinf must be reset alongside.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycle 1: SCAN.
- Cycle 2: ASSIGN pulse.
- Cycle 3: first act_read.
- With no stall, READ issues one read per cycle for num_words cycles.
- DRAIN lasts until the last response arrives. UNASSIGN follows, then SCAN on the next cycle.
- A response appears on out_* one cycle after its act_read_valid.
- mask=0 or num_words=0: cycle 1 SCAN, cycle 2 FLUSH (FIFO empty), cycle 3 DONE, cycle 4 IDLE.
- done never coincides with a non-empty FIFO.
- No combinational path from any input to any output except out_ready→FIFO pop (internal).

## Test plan
- Basic read-back:
  - Preload memories 0 and 2, word k = {4k+3,4k+2,4k+1,4k}.
  - mask=8'h05, base=0, num_words=16, out_ready=1.
  - Expect 32 beats, mem 0 then mem 2, addr 0..15, out_data 32'h03020100..32'h3f3e3d3c.
  - out_last only on mem 2 addr 15; one assign and one unassign per memory; one done.
- Backpressure:
  - Same stimulus with out_ready toggling 1 cycle on / 3 off.
  - No word lost or duplicated.
  - outstanding + fifo_count never exceeds 4.
  - Order and tags identical to the basic test.
- Wrap-around:
  - base=12'hffe, num_words=4, mask=8'h80.
  - act_read_addr = ffe, fff, 000, 001; out_mem=7.
- Empty operation:
  - mask=0 or num_words=0.
  - No command or read pulses; done at cycle 3; busy high cycles 1–3.
- Reset mid-READ of memory 1:
  - Next cycle: busy=0, out_valid=0, act_read=0, done=0.
  - New start runs cleanly.
  - start asserted while busy is ignored.
- Spurious act_read_valid in IDLE:
  - protocol_err=1 and remains set.
  - No FIFO push.
